// File: rtl/cache_axi_rd_arbiter_pkg.sv
// Shared definitions for the cache AXI read-channel arbiter.
// Holds the FSM state encoding, default AXI ids for the two caches and the fixed
// AR size/burst values driven toward the SoC bridge.
package cache_axi_rd_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAddr = 2'd1,
    StData = 2'd2
  } state_e;

  localparam logic [3:0] ICACHE_ID_DEFAULT = 4'd0;
  localparam logic [3:0] DCACHE_ID_DEFAULT = 4'd1;

  // 4-byte beats, incrementing bursts.
  localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

endpackage

// File: rtl/cache_axi_rd_arbiter_if.sv
// Signal bundle for the cache AXI read-channel arbiter.
// Carries both cache-side read channels (i_*, d_*) and the shared AXI AR/R
// channel (m_*). Modport master is the arbiter's view; modport slave is the view of
// the surrounding environment (the two caches plus the AXI bridge).
interface cache_axi_rd_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4
);

  // Icache side
  logic [ADDR_WIDTH-1:0] i_araddr;
  logic [7:0]            i_arlen;
  logic                  i_arvalid;
  logic                  i_arready;
  logic [DATA_WIDTH-1:0] i_rdata;
  logic                  i_rvalid;
  logic                  i_rlast;
  logic                  i_rready;

  // Dcache side
  logic [ADDR_WIDTH-1:0] d_araddr;
  logic [7:0]            d_arlen;
  logic                  d_arvalid;
  logic                  d_arready;
  logic [DATA_WIDTH-1:0] d_rdata;
  logic                  d_rvalid;
  logic                  d_rlast;
  logic                  d_rready;

  // Shared AXI read channel
  logic [ID_WIDTH-1:0]   m_arid;
  logic [ADDR_WIDTH-1:0] m_araddr;
  logic [7:0]            m_arlen;
  logic [2:0]            m_arsize;
  logic [1:0]            m_arburst;
  logic                  m_arvalid;
  logic                  m_arready;
  logic [ID_WIDTH-1:0]   m_rid;
  logic [DATA_WIDTH-1:0] m_rdata;
  logic                  m_rvalid;
  logic                  m_rlast;
  logic                  m_rready;

  modport master (
    input  i_araddr, i_arlen, i_arvalid, i_rready,
    output i_arready, i_rdata, i_rvalid, i_rlast,
    input  d_araddr, d_arlen, d_arvalid, d_rready,
    output d_arready, d_rdata, d_rvalid, d_rlast,
    output m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready,
    input  m_arready, m_rid, m_rdata, m_rvalid, m_rlast
  );

  modport slave (
    output i_araddr, i_arlen, i_arvalid, i_rready,
    input  i_arready, i_rdata, i_rvalid, i_rlast,
    output d_araddr, d_arlen, d_arvalid, d_rready,
    input  d_arready, d_rdata, d_rvalid, d_rlast,
    input  m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready,
    output m_arready, m_rid, m_rdata, m_rvalid, m_rlast
  );

endinterface

// File: rtl/cache_axi_rd_arbiter_grant.sv
// Winner select for the cache read arbiter.
// Ports: clk/rst (sync, active-high), i_req_i/d_req_i (cache arvalids), take_i (a grant
// is being issued this cycle), gnt_d_o (1 = dcache wins, 0 = icache wins).
// Optional macro ARB_ROUND_ROBIN_EN: when defined, a last_grant register (reset to icache)
// breaks ties toward the requester not granted last; otherwise dcache always wins ties.
module cache_axi_rd_arbiter_grant (
  input  logic clk,
  input  logic rst,
  input  logic i_req_i,
  input  logic d_req_i,
  input  logic take_i,
  output logic gnt_d_o
);

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_q, last_grant_d;  // 1 = dcache was granted last

  always_comb begin
    gnt_d_o      = d_req_i;
    if (i_req_i && d_req_i) begin
      gnt_d_o = ~last_grant_q;
    end
    last_grant_d = take_i ? gnt_d_o : last_grant_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  // Fixed priority: dcache misses stall the pipeline, so they go first.
  assign gnt_d_o = d_req_i;

  logic unused_grant;
  assign unused_grant = ^{clk, rst, i_req_i, take_i};
`endif

endmodule

// File: rtl/cache_axi_rd_arbiter.sv
// Shares one AXI read channel (AR + R) between the icache and dcache.
// Ports: clk, rst (sync, active-high), bus (cache_axi_rd_arbiter_if.master: i_*/d_* cache
// channels and m_* AXI channel), err (sticky id/length protocol error).
// One transaction at a time: IDLE grants and latches, ADDR drives AR, DATA routes beats
// to the owner until the rlast handshake. Tie-break policy selected by macro
// ARB_ROUND_ROBIN_EN (see cache_axi_rd_arbiter_grant).
module cache_axi_rd_arbiter
  import cache_axi_rd_arbiter_pkg::*;
#(
  parameter int unsigned         ADDR_WIDTH = 32,
  parameter int unsigned         DATA_WIDTH = 32,
  parameter int unsigned         ID_WIDTH   = 4,
  parameter logic [ID_WIDTH-1:0] ICACHE_ID  = ID_WIDTH'(ICACHE_ID_DEFAULT),
  parameter logic [ID_WIDTH-1:0] DCACHE_ID  = ID_WIDTH'(DCACHE_ID_DEFAULT)
) (
  input  logic                   clk,
  input  logic                   rst,
  cache_axi_rd_arbiter_if.master bus,
  output logic                   err
);

  state_e                state_q, state_d;
  logic                  owner_d_q, owner_d_d;  // 1 = dcache owns the channel
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  req_any, take, gnt_d, beat_hs;
  logic [DATA_WIDTH-1:0] rdata;

  assign req_any = bus.i_arvalid | bus.d_arvalid;
  assign take    = (state_q == StIdle) && req_any;

  cache_axi_rd_arbiter_grant u_grant (
    .clk     (clk),
    .rst     (rst),
    .i_req_i (bus.i_arvalid),
    .d_req_i (bus.d_arvalid),
    .take_i  (take),
    .gnt_d_o (gnt_d)
  );

  // Data is fanned out to both caches; only the owner ever sees rvalid.
  assign rdata       = bus.m_rdata;
  assign bus.i_rdata = rdata;
  assign bus.d_rdata = rdata;
  assign err         = err_q;

  always_comb begin
    state_d       = state_q;
    owner_d_d     = owner_d_q;
    addr_d        = addr_q;
    len_d         = len_q;
    id_d          = id_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    beat_hs       = 1'b0;
    bus.i_arready = 1'b0;
    bus.d_arready = 1'b0;
    bus.i_rvalid  = 1'b0;
    bus.i_rlast   = 1'b0;
    bus.d_rvalid  = 1'b0;
    bus.d_rlast   = 1'b0;
    bus.m_arvalid = 1'b0;
    bus.m_rready  = 1'b0;
    bus.m_arid    = id_q;
    bus.m_araddr  = addr_q;
    bus.m_arlen   = len_q;
    bus.m_arsize  = AXI_SIZE_WORD;
    bus.m_arburst = AXI_BURST_INCR;

    unique case (state_q)
      StIdle: begin
        if (req_any) begin
          owner_d_d     = gnt_d;
          addr_d        = gnt_d ? bus.d_araddr : bus.i_araddr;
          len_d         = gnt_d ? bus.d_arlen : bus.i_arlen;
          id_d          = gnt_d ? DCACHE_ID : ICACHE_ID;
          bus.i_arready = ~gnt_d;
          bus.d_arready = gnt_d;
          state_d       = StAddr;
        end
      end
      StAddr: begin
        bus.m_arvalid = 1'b1;
        if (bus.m_arready) begin
          cnt_d   = 8'd0;
          state_d = StData;
        end
      end
      StData: begin
        if (owner_d_q) begin
          bus.m_rready = bus.d_rready;
          bus.d_rvalid = bus.m_rvalid;
          bus.d_rlast  = bus.m_rlast;
        end else begin
          bus.m_rready = bus.i_rready;
          bus.i_rvalid = bus.m_rvalid;
          bus.i_rlast  = bus.m_rlast;
        end
        beat_hs = bus.m_rvalid & bus.m_rready;
        if (bus.m_rvalid && (bus.m_rid != id_q)) begin
          err_d = 1'b1;
        end
        if (beat_hs) begin
          cnt_d = cnt_q + 8'd1;
          if (bus.m_rlast) begin
            if (cnt_q != len_q) begin
              err_d = 1'b1;
            end
            state_d = StIdle;
          end else if (cnt_q >= len_q) begin
            // Beat at or past the expected last one without rlast.
            err_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      owner_d_q <= 1'b0;
      addr_q    <= '0;
      len_q     <= 8'd0;
      id_q      <= ICACHE_ID;
      cnt_q     <= 8'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_d_q <= owner_d_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      id_q      <= id_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_cache_axi_rd_arbiter.sv
// Directed self-checking bench for cache_axi_rd_arbiter.
module tb_cache_axi_rd_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RoundRobin = 1'b1;
`else
  localparam bit RoundRobin = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  cache_axi_rd_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) bus ();

  cache_axi_rd_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .err (err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Requests must already be driven; checks the grant pulse, the AR phase and
  // the drop of m_arvalid once the address is accepted.
  task automatic grant(input bit to_d, input logic [31:0] addr, input logic [7:0] len);
    #1;
    chk("arready_winner", to_d ? bus.d_arready : bus.i_arready, 1'b1);
    chk("arready_loser", to_d ? bus.i_arready : bus.d_arready, 1'b0);
    tick();
    if (to_d) bus.d_arvalid = 1'b0;
    else      bus.i_arvalid = 1'b0;
    #1;
    chk("m_arvalid_addr", bus.m_arvalid, 1'b1);
    chk("m_araddr", bus.m_araddr, addr);
    chk("m_arlen", bus.m_arlen, len);
    chk("m_arid", bus.m_arid, to_d ? 4'd1 : 4'd0);
    chk("m_arsize", bus.m_arsize, 3'b010);
    chk("m_arburst", bus.m_arburst, 2'b01);
    bus.m_arready = 1'b1;
    tick();
    bus.m_arready = 1'b0;
    #1;
    chk("m_arvalid_drop", bus.m_arvalid, 1'b0);
  endtask

  // Slave returns nbeats beats; beats in [stall_lo, stall_hi] see one cycle of owner
  // backpressure first (non-owner rready held high to prove it is not forwarded).
  task automatic burst(input bit to_d, input logic [3:0] rid, input int nbeats,
                       input bit last_on_final, input int stall_lo, input int stall_hi);
    for (int b = 0; b < nbeats; b++) begin
      bus.m_rvalid = 1'b1;
      bus.m_rid    = rid;
      bus.m_rdata  = {to_d ? 8'hdd : 8'h11, 16'h0, 8'(b)};
      bus.m_rlast  = last_on_final && (b == nbeats - 1);
      if (b >= stall_lo && b <= stall_hi) begin
        bus.i_rready = to_d;
        bus.d_rready = ~to_d;
        #1;
        chk("m_rready_stall", bus.m_rready, 1'b0);
        chk("owner_rvalid_stall", to_d ? bus.d_rvalid : bus.i_rvalid, 1'b1);
        tick();
      end
      bus.i_rready = ~to_d;
      bus.d_rready = to_d;
      #1;
      chk("owner_rvalid", to_d ? bus.d_rvalid : bus.i_rvalid, 1'b1);
      chk("owner_rdata", to_d ? bus.d_rdata : bus.i_rdata, {to_d ? 8'hdd : 8'h11, 16'h0, 8'(b)});
      chk("owner_rlast", to_d ? bus.d_rlast : bus.i_rlast, last_on_final && (b == nbeats - 1));
      chk("other_rvalid", to_d ? bus.i_rvalid : bus.d_rvalid, 1'b0);
      chk("other_rlast", to_d ? bus.i_rlast : bus.d_rlast, 1'b0);
      chk("m_rready", bus.m_rready, 1'b1);
      chk("other_arready_busy", to_d ? bus.i_arready : bus.d_arready, 1'b0);
      tick();
    end
    bus.m_rvalid = 1'b0;
    bus.m_rlast  = 1'b0;
    bus.i_rready = 1'b0;
    bus.d_rready = 1'b0;
  endtask

  initial begin
    bus.i_araddr  = '0;
    bus.i_arlen   = '0;
    bus.i_arvalid = 1'b0;
    bus.i_rready  = 1'b0;
    bus.d_araddr  = '0;
    bus.d_arlen   = '0;
    bus.d_arvalid = 1'b0;
    bus.d_rready  = 1'b0;
    bus.m_arready = 1'b0;
    bus.m_rid     = '0;
    bus.m_rdata   = '0;
    bus.m_rvalid  = 1'b0;
    bus.m_rlast   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_m_arvalid", bus.m_arvalid, 1'b0);
    chk("rst_m_rready", bus.m_rready, 1'b0);
    chk("rst_m_araddr", bus.m_araddr, 32'h0);
    chk("rst_m_arlen", bus.m_arlen, 8'h0);
    chk("rst_m_arid", bus.m_arid, 4'd0);
    chk("rst_err", err, 1'b0);
    chk("rst_i_arready", bus.i_arready, 1'b0);
    chk("rst_d_rvalid", bus.d_rvalid, 1'b0);

    // Icache alone, 8-beat burst.
    bus.i_araddr  = 32'hbfc0_0000;
    bus.i_arlen   = 8'd7;
    bus.i_arvalid = 1'b1;
    grant(1'b0, 32'hbfc0_0000, 8'd7);
    burst(1'b0, 4'd0, 8, 1'b1, -1, -1);
    #1;
    chk("t1_err", err, 1'b0);
    chk("t1_idle_rready", bus.m_rready, 1'b0);

    // Simultaneous requests; dcache burst carries backpressure on beats 3..5.
    bus.i_araddr  = 32'h8000_0000;
    bus.i_arlen   = 8'd15;
    bus.d_araddr  = 32'h8000_0040;
    bus.d_arlen   = 8'd15;
    bus.i_arvalid = 1'b1;
    bus.d_arvalid = 1'b1;
    grant(1'b1, 32'h8000_0040, 8'd15);
    burst(1'b1, 4'd1, 16, 1'b1, 3, 5);
    chk("t3_err", err, 1'b0);
    grant(1'b0, 32'h8000_0000, 8'd15);
    burst(1'b0, 4'd0, 16, 1'b1, -1, -1);
    chk("t2_err", err, 1'b0);

    // AR stall for 5 cycles while icache keeps requesting.
    bus.i_araddr  = 32'h1234_5670;
    bus.i_arlen   = 8'd3;
    bus.i_arvalid = 1'b1;
    #1;
    chk("t6_arready", bus.i_arready, 1'b1);
    tick();
    bus.i_araddr = 32'hdead_beef;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t6_arvalid", bus.m_arvalid, 1'b1);
      chk("t6_araddr", bus.m_araddr, 32'h1234_5670);
      chk("t6_arlen", bus.m_arlen, 8'd3);
      chk("t6_arid", bus.m_arid, 4'd0);
      chk("t6_no_arready", bus.i_arready, 1'b0);
      tick();
    end
    bus.i_arvalid = 1'b0;
    bus.m_arready = 1'b1;
    tick();
    bus.m_arready = 1'b0;
    burst(1'b0, 4'd0, 4, 1'b1, -1, -1);
    chk("t6_err", err, 1'b0);

    // Early rlast: arlen=7 but rlast on beat index 4.
    bus.d_araddr  = 32'h0000_2000;
    bus.d_arlen   = 8'd7;
    bus.d_arvalid = 1'b1;
    grant(1'b1, 32'h0000_2000, 8'd7);
    burst(1'b1, 4'd1, 5, 1'b1, -1, -1);
    #1;
    chk("t4a_err", err, 1'b1);
    chk("t4a_idle_arvalid", bus.m_arvalid, 1'b0);

    // Tie after a dcache grant: round robin picks icache, fixed priority dcache.
    bus.i_araddr  = 32'h0000_3000;
    bus.i_arlen   = 8'd0;
    bus.d_araddr  = 32'h0000_4000;
    bus.d_arlen   = 8'd0;
    bus.i_arvalid = 1'b1;
    bus.d_arvalid = 1'b1;
    grant(!RoundRobin, RoundRobin ? 32'h0000_3000 : 32'h0000_4000, 8'd0);
    bus.i_arvalid = 1'b0;
    bus.d_arvalid = 1'b0;
    burst(!RoundRobin, RoundRobin ? 4'd0 : 4'd1, 1, 1'b1, -1, -1);
    chk("t4a_err_sticky", err, 1'b1);

    // Reset during beat 2 of an icache burst.
    bus.i_araddr  = 32'hbfc0_0100;
    bus.i_arlen   = 8'd7;
    bus.i_arvalid = 1'b1;
    grant(1'b0, 32'hbfc0_0100, 8'd7);
    burst(1'b0, 4'd0, 2, 1'b0, -1, -1);
    bus.m_rvalid = 1'b1;
    bus.m_rid    = 4'd0;
    bus.i_rready = 1'b1;
    rst          = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("t5_i_rvalid", bus.i_rvalid, 1'b0);
    chk("t5_m_rready", bus.m_rready, 1'b0);
    chk("t5_m_arvalid", bus.m_arvalid, 1'b0);
    chk("t5_m_araddr", bus.m_araddr, 32'h0);
    chk("t5_m_arlen", bus.m_arlen, 8'h0);
    chk("t5_m_arid", bus.m_arid, 4'd0);
    chk("t5_err", err, 1'b0);
    bus.m_rvalid  = 1'b0;
    bus.i_rready  = 1'b0;
    bus.d_araddr  = 32'h0000_5000;
    bus.d_arlen   = 8'd1;
    bus.d_arvalid = 1'b1;
    grant(1'b1, 32'h0000_5000, 8'd1);
    burst(1'b1, 4'd1, 2, 1'b1, -1, -1);
    chk("t5_post_err", err, 1'b0);

    // Wrong rid during an icache burst; err must stick.
    bus.i_araddr  = 32'h0000_6000;
    bus.i_arlen   = 8'd3;
    bus.i_arvalid = 1'b1;
    grant(1'b0, 32'h0000_6000, 8'd3);
    burst(1'b0, 4'd1, 4, 1'b1, -1, -1);
    chk("t4b_err", err, 1'b1);
    tick();
    tick();
    chk("t4b_err_sticky", err, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
